// File: rtl/bit_serial_adder.sv
// Serial WIDTH-bit add/subtract: one full_adder bit per clock, LSB first, with a registered carry.
// Latency WIDTH+1 cycles from accept to out_valid; out_ready low in DONE holds the result.

module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
    logic [WIDTH-1:0]   sum_q;
    logic [CW-1:0]      cnt_q;
    logic               carry_q, cout_q, ovf_q;
    logic               fa_s, fa_c, c_msb;

    full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    assign res_d = {fa_s, res_q[WIDTH-1:1]};
    // On the MSB cycle the registered carry is exactly the carry into the MSB.
    assign c_msb = carry_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= Sub ? ~B : B;
                        carry_q <= Sub;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_c;
                        ovf_q   <= c_msb ^ fa_c;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Overflow  = ovf_q;
endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and random checks of bit_serial_adder at WIDTH=8 and WIDTH=2 against an arithmetic reference.
module tb_bit_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       iv8 = 0, ir8, ov8, or8 = 0, sub8 = 0, co8, of8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic       iv2 = 0, ir2, ov2, or2 = 0, sub2 = 0, co2, of2;
    logic [1:0] a2 = 0, b2 = 0, s2;

    bit_serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8), .Sub(sub8),
        .out_valid(ov8), .out_ready(or8), .Sum(s8), .Cout(co8), .Overflow(of8));
    bit_serial_adder #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2), .Sub(sub2),
        .out_valid(ov2), .out_ready(or2), .Sum(s2), .Cout(co2), .Overflow(of2));

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } res_t;

    res_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input int w, input logic [7:0] a, input logic [7:0] b, input logic sub);
        res_t r;
        int m   = (1 << w) - 1;
        int aa  = int'(a) & m;
        int bb  = sub ? (~int'(b)) & m : int'(b) & m;
        int s   = aa + bb + int'(sub);
        int msb = w - 1;
        r.sum  = 8'(s & m);
        r.cout = ((s >> w) & 1) == 1;
        r.ovf  = (((aa >> msb) & 1) == ((bb >> msb) & 1)) && (((s >> msb) & 1) != ((aa >> msb) & 1));
        return r;
    endfunction

    // {in_ready, out_valid, Cout, Overflow, Sum}
    function automatic logic [11:0] obs(input bit w2);
        if (w2) return {ir2, ov2, co2, of2, 6'b0, s2};
        return {ir8, ov8, co8, of8, s8};
    endfunction

    task automatic set_in(input bit w2, input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
        if (w2) begin iv2 = v; a2 = a[1:0]; b2 = b[1:0]; sub2 = s; end
        else    begin iv8 = v; a8 = a;      b8 = b;      sub8 = s; end
    endtask

    task automatic set_ordy(input bit w2, input logic v);
        if (w2) or2 = v; else or8 = v;
    endtask

    task automatic op(input bit w2, input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input int hold, input bit junk, output res_t got);
        int w = w2 ? 2 : 8;
        logic [11:0] o, prev, done0;
        res_t exp;
        o = obs(w2);
        prev = o;
        chk("idle_in_ready", 32'(o[11]), 1);
        chk("idle_out_valid", 32'(o[10]), 0);
        set_in(w2, 1'b1, a, b, sub);
        step();
        sb.push_back(model(w, a, b, sub));
        if (junk) set_in(w2, 1'b1, 8'hAA, 8'hAA, ~sub);
        else      set_in(w2, 1'b0, 8'h00, 8'h00, 1'b0);
        for (int i = 1; i < w; i++) begin
            step();
            o = obs(w2);
            chk("run_out_valid", 32'(o[10]), 0);
            chk("run_in_ready", 32'(o[11]), 0);
            chk("run_hold", 32'(o[9:0]), 32'(prev[9:0]));
        end
        step();
        set_in(w2, 1'b0, 8'h00, 8'h00, 1'b0);
        done0 = obs(w2);
        chk("latency_out_valid", 32'(done0[10]), 1);
        for (int h = 0; h < hold; h++) begin
            step();
            o = obs(w2);
            chk("bp_stable", 32'(o), 32'(done0));
            chk("bp_in_ready", 32'(o[11]), 0);
        end
        set_ordy(w2, 1'b1);
        o = obs(w2);
        got.sum  = o[7:0];
        got.cout = o[9];
        got.ovf  = o[8];
        if (sb.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            exp = sb.pop_front();
            chk("sum", 32'(got.sum), 32'(exp.sum));
            chk("cout", 32'(got.cout), 32'(exp.cout));
            chk("ovf", 32'(got.ovf), 32'(exp.ovf));
        end
        step();
        set_ordy(w2, 1'b0);
        o = obs(w2);
        chk("release_out_valid", 32'(o[10]), 0);
        chk("release_in_ready", 32'(o[11]), 1);
    endtask

    initial begin
        res_t r;
        logic [11:0] o;

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        o = obs(0);
        chk("rst_in_ready", 32'(o[11]), 1);
        chk("rst_out_valid", 32'(o[10]), 0);
        chk("rst_sum", 32'(o[7:0]), 32'h00);
        chk("rst_cout", 32'(o[9]), 0);
        chk("rst_ovf", 32'(o[8]), 0);

        op(0, 8'h35, 8'h4A, 0, 0, 0, r);
        chk("add_35_4a", 32'(r), 32'({8'h7F, 1'b0, 1'b0}));
        op(0, 8'hFF, 8'h01, 0, 0, 0, r);
        chk("add_ff_01", 32'(r), 32'({8'h00, 1'b1, 1'b0}));
        op(0, 8'h7F, 8'h01, 0, 0, 0, r);
        chk("add_7f_01", 32'(r), 32'({8'h80, 1'b0, 1'b1}));
        op(0, 8'h10, 8'h20, 1, 0, 0, r);
        chk("sub_10_20", 32'(r), 32'({8'hF0, 1'b0, 1'b0}));
        op(0, 8'h80, 8'h01, 1, 0, 0, r);
        chk("sub_80_01", 32'(r), 32'({8'h7F, 1'b1, 1'b1}));
        op(0, 8'h55, 8'h55, 1, 0, 0, r);
        chk("sub_55_55_sum", 32'(r.sum), 32'h00);
        chk("sub_55_55_cout", 32'(r.cout), 1);

        op(0, 8'h21, 8'h13, 0, 5, 1, r);
        chk("junk_bp_result", 32'(r), 32'({8'h34, 1'b0, 1'b0}));

        // Abort on the third RUN edge.
        set_in(0, 1'b1, 8'h12, 8'h34, 1'b0);
        step();
        set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        o = obs(0);
        chk("abort_in_ready", 32'(o[11]), 1);
        chk("abort_out_valid", 32'(o[10]), 0);
        chk("abort_sum", 32'(o[7:0]), 32'h00);
        chk("abort_flags", 32'(o[9:8]), 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_valid", 32'(obs(0) >> 10) & 32'h1, 0);
        end
        op(0, 8'h01, 8'h02, 0, 0, 0, r);
        chk("after_abort", 32'(r.sum), 32'h03);

        for (int i = 0; i < 1000; i++) begin
            op(i[0], 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
               1'($urandom), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
